// File: rtl/s38584_pkg.sv
// rtl/s38584_pkg.sv - shared state encoding and select-code layout for the s38584 sequencer
package s38584_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, EMIT} state_t;

  localparam int SEL_W = 8;

  // Bit positions of each cone select input inside the code byte
  localparam int G6_POS  = 0;
  localparam int G7_POS  = 1;
  localparam int G8_POS  = 2;
  localparam int G9_POS  = 3;
  localparam int G16_POS = 4;
  localparam int G19_POS = 5;
  localparam int G28_POS = 6;
  localparam int G31_POS = 7;

endpackage

// File: rtl/s38584_sel_table.sv
// rtl/s38584_sel_table.sv - select-code table with cleared-on-reset write port and combinational read
module s38584_sel_table
  import s38584_pkg::*;
#(
  parameter int NSEL = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [4:0]       wr_addr,
  input  logic [SEL_W-1:0] wr_data,
  input  logic [4:0]       rd_addr,
  output logic [SEL_W-1:0] rd_data
);

  logic [SEL_W-1:0] mem [NSEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEL; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/s38584_sel_sequencer.sv
// rtl/s38584_sel_sequencer.sv - walks select codes into the s38584 cone, samples n4250, packs words
module s38584_sel_sequencer
  import s38584_pkg::*;
#(
  parameter int NSEL   = 32,
  parameter int WORD_W = 16,
  parameter int SETTLE = 2
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [SEL_W-1:0]  cfg_data,
  input  logic [5:0]        len,
  input  logic              start,
  output logic [SEL_W-1:0]  sel_code,
  output logic              g35_en,
  input  logic              cone_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [4:0]        idx;
  logic [4:0]        bit_cnt;
  logic [3:0]        settle_cnt;
  logic [5:0]        len_q;
  logic [WORD_W-1:0] shift;

  logic [4:0]        rd_addr;
  logic [SEL_W-1:0]  rd_data;
  logic [WORD_W-1:0] shift_nxt;
  logic              last;
  logic              word_full;
  logic              len_bad;

  // The read port always looks one entry ahead so the next code is ready to register
  assign rd_addr   = (state == IDLE) ? 5'd0 : idx + 5'd1;
  assign shift_nxt = shift | ({{(WORD_W-1){1'b0}}, cone_bit} << bit_cnt);
  assign last      = ({1'b0, idx} == (len_q - 6'd1));
  assign word_full = (({1'b0, bit_cnt} + 6'd1) == 6'(WORD_W));
  assign len_bad   = (len == 6'd0) || (int'(len) > NSEL);

  s38584_sel_table #(.NSEL(NSEL)) u_table (
    .clk     (CK),
    .rst_n   (RN),
    .we      (cfg_we && (state == IDLE)),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state      <= IDLE;
      idx        <= '0;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      len_q      <= '0;
      shift      <= '0;
      sel_code   <= '0;
      g35_en     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          sel_code <= '0;
          if (start) begin
            if (len_bad) begin
              err <= 1'b1;
            end else begin
              len_q      <= len;
              idx        <= '0;
              bit_cnt    <= '0;
              settle_cnt <= '0;
              shift      <= '0;
              // A same-cycle write to entry 0 must be seen by this run
              sel_code   <= (cfg_we && cfg_addr == 5'd0) ? cfg_data : rd_data;
              busy       <= 1'b1;
              state      <= DRIVE;
            end
          end
        end
        DRIVE: begin
          if (settle_cnt == 4'(SETTLE - 1)) begin
            settle_cnt <= '0;
            g35_en     <= 1'b1;
            state      <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CAPTURE: begin
          g35_en  <= 1'b0;
          shift   <= shift_nxt;
          bit_cnt <= bit_cnt + 5'd1;
          if (word_full || last) begin
            out_valid <= 1'b1;
            out_data  <= shift_nxt;
            state     <= EMIT;
          end else begin
            idx      <= idx + 5'd1;
            sel_code <= rd_data;
            state    <= DRIVE;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            if (last) begin
              sel_code <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              idx      <= idx + 5'd1;
              sel_code <= rd_data;
              state    <= DRIVE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s38584_sel_sequencer.sv
// tb/tb_s38584_sel_sequencer.sv - self-checking bench for s38584_sel_sequencer
module tb_s38584_sel_sequencer;
  import s38584_pkg::*;

  localparam int NSEL   = 32;
  localparam int WORD_W = 16;
  localparam int SETTLE = 2;

  logic              CK = 1'b0;
  logic              RN = 1'b1;
  logic              cfg_we = 1'b0;
  logic [4:0]        cfg_addr = '0;
  logic [7:0]        cfg_data = '0;
  logic [5:0]        len = '0;
  logic              start = 1'b0;
  logic [7:0]        sel_code;
  logic              g35_en;
  logic              cone_bit;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WORD_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int words_seen = 0;

  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] exp_w;
  logic [7:0]        sel_seen[$];
  logic [7:0]        tbl_model[NSEL];
  logic [31:0]       pattern = '0;
  logic [4:0]        samp_i = '0;
  logic              clr_samp = 1'b0;

  typedef struct {
    int          l;
    logic [31:0] pat;
    int          lat;
    int          nw;
  } vec_t;
  vec_t vecs[6];

  s38584_sel_sequencer #(.NSEL(NSEL), .WORD_W(WORD_W), .SETTLE(SETTLE)) dut (
    .CK        (CK),
    .RN        (RN),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .len       (len),
    .start     (start),
    .sel_code  (sel_code),
    .g35_en    (g35_en),
    .cone_bit  (cone_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 CK = ~CK;

  // Cone stand-in: the i-th capture of a run sees pattern[i]
  assign cone_bit = pattern[samp_i];
  always @(posedge CK) begin
    if (clr_samp) samp_i <= '0;
    else if (g35_en) samp_i <= samp_i + 5'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge CK) begin
    if (g35_en) sel_seen.push_back(sel_code);
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (out_valid && out_ready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else begin
        exp_w = exp_q.pop_front();
        chk("word", {16'h0, out_data}, {16'h0, exp_w});
      end
    end
  end

  task automatic cfg_write(input int a, input logic [7:0] d);
    @(negedge CK);
    cfg_we = 1'b1; cfg_addr = 5'(a); cfg_data = d;
    @(posedge CK); #1;
    cfg_we = 1'b0;
    tbl_model[a] = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_sel"},   {24'h0, sel_code}, 32'h0);
    chk({tag, "_g35"},   {31'h0, g35_en}, 32'h0);
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_data"},  {16'h0, out_data}, 32'h0);
    chk({tag, "_busy"},  {31'h0, busy}, 32'h0);
    chk({tag, "_done"},  {31'h0, done}, 32'h0);
    chk({tag, "_err"},   {31'h0, err}, 32'h0);
  endtask

  task automatic run(input int l, input logic [31:0] pat, input int lat, input int nw,
                     input int hold, input bit poke, input int wr0);
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] hd;
    logic [7:0]        hs;
    int b, cyc, w0, d0;
    w = '0; b = 0;
    for (int i = 0; i < l; i++) begin
      w[b] = pat[i];
      b++;
      if (b == WORD_W || i == l - 1) begin
        exp_q.push_back(w);
        w = '0; b = 0;
      end
    end
    w0 = words_seen; d0 = done_cnt;
    sel_seen.delete();
    pattern = pat;
    out_ready = (hold == 0);
    @(negedge CK);
    start = 1'b1; len = 6'(l); clr_samp = 1'b1;
    if (wr0 >= 0) begin
      cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 8'(wr0);
      tbl_model[0] = 8'(wr0);
    end
    @(posedge CK); #1;
    start = 1'b0; clr_samp = 1'b0; cfg_we = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge CK); #1;
      cyc++;
      if (poke) begin
        cfg_we = (cyc == 4); start = (cyc == 4);
        cfg_addr = 5'd1; cfg_data = 8'hEE;
        if (cyc == 4) len = 6'd1;
      end
    end
    cfg_we = 1'b0; start = 1'b0;
    chk("first_valid_latency", cyc, lat);
    if (hold > 0) begin
      hd = out_data; hs = sel_code;
      for (int i = 0; i < hold; i++) begin
        @(posedge CK); #1;
        chk("hold_valid", {31'h0, out_valid}, 32'h1);
        chk("hold_data", {16'h0, out_data}, {16'h0, hd});
        chk("hold_sel", {24'h0, sel_code}, {24'h0, hs});
      end
      out_ready = 1'b1;
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 2000) begin
      @(posedge CK); #1;
      cyc++;
    end
    chk("done_pulses", done_cnt - d0, 1);
    chk("word_count", words_seen - w0, nw);
    chk("busy_after", {31'h0, busy}, 32'h0);
    chk("sel_idle", {24'h0, sel_code}, 32'h0);
    chk("sample_count", sel_seen.size(), l);
    for (int i = 0; i < l && i < sel_seen.size(); i++)
      chk("sel_step", {24'h0, sel_seen[i]}, {24'h0, tbl_model[i]});
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < NSEL; i++) tbl_model[i] = '0;
    vecs[0] = '{3,  32'h0000_0007, 9,  1};
    vecs[1] = '{20, 32'h5555_5555, 48, 2};
    vecs[2] = '{16, 32'h0000_A5C3, 48, 1};
    vecs[3] = '{17, 32'h0001_FFFF, 48, 2};
    vecs[4] = '{32, 32'hDEAD_BEEF, 48, 2};
    vecs[5] = '{1,  32'h0000_0001, 3,  1};

    #2 RN = 1'b0;
    #1 check_idle_outputs("reset");
    @(negedge CK); RN = 1'b1;

    // Illegal lengths: err pulse only
    for (int k = 0; k < 2; k++) begin
      @(negedge CK);
      start = 1'b1; len = (k == 0) ? 6'd0 : 6'd33;
      @(posedge CK); #1;
      start = 1'b0;
      chk("err_pulse", {31'h0, err}, 32'h1);
      chk("err_busy", {31'h0, busy}, 32'h0);
      @(posedge CK); #1;
      chk("err_clear", {31'h0, err}, 32'h0);
      chk("err_no_valid", {31'h0, out_valid}, 32'h0);
    end

    cfg_write(0, 8'h00);
    cfg_write(1, 8'h10);
    cfg_write(2, 8'h30);
    for (int i = 3; i < NSEL; i++) cfg_write(i, 8'(i * 37 + 5));

    for (int v = 0; v < 6; v++)
      run(vecs[v].l, vecs[v].pat, vecs[v].lat, vecs[v].nw, 0, 1'b0, -1);

    run(2, 32'h3, 6, 1, 10, 1'b0, -1);
    run(1, 32'h1, 3, 1, 0, 1'b0, 8'h5A);

    cfg_write(0, 8'h11);
    cfg_write(1, 8'h22);
    cfg_write(2, 8'h33);
    cfg_write(3, 8'h44);
    run(4, 32'hA, 12, 1, 0, 1'b1, -1);
    run(4, 32'h5, 12, 1, 0, 1'b0, -1);

    // Reset while driving entry 5 of a 10-entry run
    begin
      int w0;
      w0 = words_seen;
      pattern = 32'h3FF;
      @(negedge CK);
      start = 1'b1; len = 6'd10; clr_samp = 1'b1;
      @(posedge CK); #1;
      start = 1'b0; clr_samp = 1'b0;
      cyc = 0;
      while (!(samp_i == 5'd5 && !g35_en) && cyc < 100) begin
        @(posedge CK); #1;
        cyc++;
      end
      chk("reach_entry5", {27'h0, samp_i}, 32'h5);
      chk("entry5_busy", {31'h0, busy}, 32'h1);
      #2 RN = 1'b0;
      #1 check_idle_outputs("abort");
      @(negedge CK); RN = 1'b1;
      chk("abort_no_word", words_seen - w0, 0);
      for (int i = 0; i < NSEL; i++) tbl_model[i] = '0;
      run(3, 32'h5, 9, 1, 0, 1'b0, -1);
    end

    chk("err_total", err_cnt, 2);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
